dist_accumulator: RTL and testbench



---
 rtl/dist_accumulator.sv | 70 +++++++
 tb/tb_dist_accumulator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dist_accumulator.sv
// dist_accumulator: batched sum-of-squares accumulator answering the distance
// control unit's EN_Acc/RST_Acc/PRE_Acc -> RDY_Acc handshake.
module dist_accumulator #(
    parameter int BATCH = 4,
    parameter int SUM_W = 24
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic                    EN_Acc,
    input  logic                    RST_Acc,
    input  logic                    PRE_Acc,
    input  logic                    VALID_Pipe,
    input  logic signed [8:0]       DIFF_Pipe,
    output logic                    RDY_Acc,
    output logic [SUM_W-1:0]        SUM_Acc,
    output logic                    OVF_Acc
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t       state;
    logic [7:0]   acc_cnt, add_cnt, mag;
    logic         sq_valid, accept;
    logic [15:0]  sq, mag_sq;
    logic [SUM_W:0] sum_ext;
    always_comb begin
        mag     = DIFF_Pipe[8] ? 8'(-DIFF_Pipe) : DIFF_Pipe[7:0];
        mag_sq  = 16'(mag) * 16'(mag);
        // the extra top bit of sum_ext is the saturation detector
        sum_ext = {1'b0, SUM_Acc} + {{(SUM_W+1-16){1'b0}}, sq};
        accept  = state == ACCUM && VALID_Pipe && acc_cnt < 8'(BATCH);
    end
    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= IDLE;
            acc_cnt  <= '0;
            add_cnt  <= '0;
            sq_valid <= 1'b0;
            sq       <= '0;
            SUM_Acc  <= '0;
            OVF_Acc  <= 1'b0;
            RDY_Acc  <= 1'b0;
        end else if (EN_Acc) begin
            if (RST_Acc) begin
                state    <= ACCUM;
                acc_cnt  <= '0;
                add_cnt  <= '0;
                sq_valid <= 1'b0;
                RDY_Acc  <= 1'b0;
                if (!PRE_Acc) begin
                    SUM_Acc <= '0;
                    OVF_Acc <= 1'b0;
                end
            end else begin
                sq_valid <= accept;
                if (accept) begin
                    sq      <= mag_sq;
                    acc_cnt <= acc_cnt + 8'd1;
                end
                if (sq_valid) begin
                    SUM_Acc <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
                    OVF_Acc <= OVF_Acc | sum_ext[SUM_W];
                    add_cnt <= add_cnt + 8'd1;
                    if (add_cnt == 8'(BATCH-1)) begin
                        state   <= DONE;
                        RDY_Acc <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_dist_accumulator.sv
// tb_dist_accumulator: two instances (BATCH=4/SUM_W=24 and BATCH=5/SUM_W=18) share
// one stimulus stream; a phase-level model feeds a scoreboard checked on RDY_Acc rises.
module tb_dist_accumulator;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, en, rst_acc, pre, valid;
    logic signed [8:0] diff;
    logic rdy0, ovf0, rdy1, ovf1;
    logic [23:0] sum0;
    logic [17:0] sum1;

    dist_accumulator #(.BATCH(4), .SUM_W(24)) dut0 (.clk(clk), .RST(rst), .EN_Acc(en),
        .RST_Acc(rst_acc), .PRE_Acc(pre), .VALID_Pipe(valid), .DIFF_Pipe(diff),
        .RDY_Acc(rdy0), .SUM_Acc(sum0), .OVF_Acc(ovf0));
    dist_accumulator #(.BATCH(5), .SUM_W(18)) dut1 (.clk(clk), .RST(rst), .EN_Acc(en),
        .RST_Acc(rst_acc), .PRE_Acc(pre), .VALID_Pipe(valid), .DIFF_Pipe(diff),
        .RDY_Acc(rdy1), .SUM_Acc(sum1), .OVF_Acc(ovf1));

    typedef struct {longint sum; bit ovf; int edge_n;} exp_t;
    exp_t q0[$], q1[$];
    int checks = 0, errors = 0, edges = 0;
    longint base[2], psum[2], last[2];
    bit movf[2], fresh[2], pend[2], phase[2];
    int cnt[2];

    function automatic longint maxv(int i); return i ? 64'd262143 : 64'd16777215; endfunction
    function automatic int bat(int i); return i ? 5 : 4; endfunction
    // total of all squares already added to the DUT sum (the fresh one is still in flight)
    function automatic longint tot(int i); return base[i] + psum[i] - (fresh[i] ? last[i] : 0); endfunction
    function automatic longint sat(int i, longint v); return v > maxv(i) ? maxv(i) : v; endfunction

    task automatic chk(string name, int i, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d at edge %0d: got %0d expected %0d", name, i, edges, act, exp);
        end
    endtask

    task automatic model_edge();
        exp_t e;
        longint d, sq;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                base[i] = 0; psum[i] = 0; last[i] = 0; cnt[i] = 0;
                movf[i] = 0; fresh[i] = 0; pend[i] = 0; phase[i] = 0;
            end else if (en) begin
                if (rst_acc) begin
                    if (pre) begin
                        movf[i] = movf[i] | (tot(i) > maxv(i));
                        base[i] = sat(i, tot(i));
                    end else begin
                        base[i] = 0;
                        movf[i] = 0;
                    end
                    psum[i] = 0; cnt[i] = 0; fresh[i] = 0; pend[i] = 0; phase[i] = 1;
                end else begin
                    fresh[i] = 0;
                    if (pend[i]) begin
                        e.sum = sat(i, tot(i));
                        e.ovf = movf[i] | (tot(i) > maxv(i));
                        e.edge_n = edges + 1;
                        if (i == 0) q0.push_back(e); else q1.push_back(e);
                        pend[i] = 0;
                    end
                    if (phase[i] && valid && cnt[i] < bat(i)) begin
                        d = longint'(diff);
                        sq = d * d;
                        psum[i] += sq; last[i] = sq; cnt[i]++; fresh[i] = 1;
                        if (cnt[i] == bat(i)) pend[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_now();
        longint s[2];
        bit o[2], r[2];
        s[0] = sum0; s[1] = sum1; o[0] = ovf0; o[1] = ovf1; r[0] = rdy0; r[1] = rdy1;
        for (int i = 0; i < 2; i++) begin
            chk("sum", i, s[i], sat(i, tot(i)));
            chk("ovf", i, o[i], movf[i] | (tot(i) > maxv(i)));
            chk("rdy", i, r[i], phase[i] && cnt[i] == bat(i) && !fresh[i]);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        edges++;
        #1;
        check_now();
    endtask

    task automatic s(input bit v, input int d);
        valid = v; diff = 9'(d);
        tick();
        valid = 1'b0;
    endtask

    task automatic racc(input bit p);
        rst_acc = 1'b1; pre = p;
        tick();
        rst_acc = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pop(int i, longint sv, bit ov);
        exp_t e;
        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            checks++; errors++;
            $display("FAIL rdy_rise dut%0d at edge %0d: got unexpected rise expected none", i, edges);
        end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk("sb_sum", i, sv, e.sum);
            chk("sb_ovf", i, ov, e.ovf);
            chk("sb_edge", i, edges, e.edge_n);
        end
    endtask

    bit prev0 = 1'b0, prev1 = 1'b0;
    always @(negedge clk) begin
        if (rdy0 && !prev0) pop(0, sum0, ovf0);
        if (rdy1 && !prev1) pop(1, sum1, ovf1);
        prev0 = rdy0;
        prev1 = rdy1;
    end

    initial begin
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        rst = 1'b1; en = 1'b1; rst_acc = 1'b0; pre = 1'b0; valid = 1'b0; diff = '0;
        idle(2);
        chk("reset_sum", 0, sum0, 0);
        chk("reset_rdy", 0, rdy0, 0);
        rst = 1'b0;
        racc(0);
        s(1, 3); s(1, -4); s(1, 0); s(1, 5);
        chk("t1_rdy_early", 0, rdy0, 0);
        idle(1);
        chk("t1_rdy", 0, rdy0, 1);
        chk("t1_sum", 0, sum0, 50);
        chk("t1_ovf", 0, ovf0, 0);
        racc(1);
        chk("t2_rdy_drop", 0, rdy0, 0);
        chk("t2_keep", 0, sum0, 50);
        for (int k = 0; k < 4; k++) s(1, 1);
        idle(1);
        chk("t2_sum", 0, sum0, 54);
        chk("t2_rdy", 0, rdy0, 1);
        racc(0);
        for (int k = 0; k < 5; k++) s(1, -255);
        idle(2);
        chk("t3_sat", 1, sum1, 262143);
        chk("t3_ovf", 1, ovf1, 1);
        chk("t3_nosat", 0, sum0, 260100);
        racc(1);
        chk("t3_soft_ovf", 1, ovf1, 1);
        chk("t3_soft_sum", 1, sum1, 262143);
        racc(0);
        chk("t3_hard_ovf", 1, ovf1, 0);
        chk("t3_hard_sum", 1, sum1, 0);
        racc(0);
        for (int k = 0; k < 7; k++) s(pat[k] == 1, 2);
        for (int k = 0; k < 3; k++) s(1, 10);
        idle(2);
        chk("t4_sum", 0, sum0, 16);
        chk("t4_rdy", 0, rdy0, 1);
        chk("t4_sum_b5", 1, sum1, 116);
        racc(0);
        s(1, 7); s(1, 7);
        racc(0);
        chk("t5_clear", 0, sum0, 0);
        chk("t5_rdy", 0, rdy0, 0);
        for (int k = 0; k < 4; k++) s(1, 1);
        idle(2);
        chk("t5_sum", 0, sum0, 4);
        racc(0);
        s(1, 3); s(1, 3);
        en = 1'b0; valid = 1'b1; diff = 9'sd9;
        idle(5);
        chk("t6_frozen_sum", 0, sum0, 9);
        chk("t6_frozen_rdy", 0, rdy0, 0);
        en = 1'b1; valid = 1'b0;
        s(1, 3); s(1, 3);
        idle(2);
        chk("t6_sum", 0, sum0, 36);
        chk("t6_rdy", 0, rdy0, 1);
        for (int k = 0; k < 3000; k++) begin
            rst = $urandom_range(0, 299) == 0;
            en = $urandom_range(0, 7) != 0;
            rst_acc = $urandom_range(0, 15) == 0;
            pre = 1'($urandom);
            valid = $urandom_range(0, 3) != 0;
            diff = 9'(int'($urandom_range(0, 510)) - 255);
            tick();
        end
        rst = 1'b0; en = 1'b1; rst_acc = 1'b0; valid = 1'b0;
        idle(3);
        chk("q0_drained", 0, q0.size(), 0);
        chk("q1_drained", 1, q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
